// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC owner, single-outstanding imem requester, in-order tagged queue.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [1:0]  id_immsrc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int unsigned PTRW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNTW = $clog2(QDEPTH + 1);
  localparam logic [CNTW-1:0] FULL = CNTW'(QDEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       req_pc_q, req_pc_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic [PTRW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]       instr_q [QDEPTH];
  logic [31:0]       qpc_q   [QDEPTH];

  logic              fetch_hs;
  logic              push;
  logic              pop;
  logic [31:0]       redirect_word;
  logic              unused_redirect_lsb;

  assign redirect_word       = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (fetch_hs) state_d = redirect ? S_DROP : S_WAIT;
      S_WAIT: begin
        if (imem_rvalid)   state_d = S_IDLE;
        else if (redirect) state_d = S_DROP;
      end
      S_DROP: if (imem_rvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs; request is masked during reset so it drops immediately
  always_comb begin
    imem_req  = (state_q == S_IDLE) && (count_q != FULL) && !reset;
    imem_addr = pc_q;
    id_valid  = (count_q != '0) && !redirect;
  end

  assign fetch_hs = imem_req & imem_gnt;
  assign push     = (state_q == S_WAIT) && imem_rvalid && !redirect;
  assign pop      = id_valid & id_ready;

  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect) begin
      // Flush by aligning the read pointer to the write pointer; no push occurs this cycle.
      pc_d     = redirect_word;
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (fetch_hs) begin
        pc_d     = pc_q + 32'd4;
        req_pc_d = pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= {RESET_PC[31:2], 2'b00};
      req_pc_q <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        instr_q[i] <= '0;
        qpc_q[i]   <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      if (push) begin
        instr_q[wr_ptr_q] <= imem_rdata;
        qpc_q[wr_ptr_q]   <= req_pc_q;
      end
    end
  end

  assign id_instr = instr_q[rd_ptr_q];
  assign id_pc    = qpc_q[rd_ptr_q];

  always_comb begin
    id_immsrc = 2'b00;
    unique case (id_instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: id_immsrc = 2'b00;
      7'b0100011:                         id_immsrc = 2'b01;
      7'b1100011:                         id_immsrc = 2'b10;
      default:                            id_immsrc = 2'b00;
    endcase
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (push) perf_fetched_q <= perf_fetched_q + 32'd1;
      if ((state_q == S_IDLE) && (count_q == FULL)) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule
